// File: rtl/reset_sequencer_pkg.sv
// gm64_reset_pkg: shared state type, default timing constants and stage indices for the reset sequencer.
package gm64_reset_pkg;
    typedef enum logic [1:0] {ASSERT, GAP, WAIT_READY, RUN} rst_seq_state_t;
    localparam int RST_NUM_STAGES     = 4;
    localparam int RST_HOLD_CYCLES    = 16;
    localparam int RST_STAGE_GAP      = 8;
    localparam int RST_TIMEOUT_CYCLES = 1024;
    localparam int STG_MEM = 0;
    localparam int STG_VIC = 1;
    localparam int STG_IO  = 2;
    localparam int STG_CPU = 3;
    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft-reset request, per-stage ready/reset and status signals of the reset sequencer.
interface reset_sequencer_if #(parameter int NUM_STAGES = gm64_reset_pkg::RST_NUM_STAGES);
    localparam int IW = $clog2(NUM_STAGES);
    logic                  soft_req;
    logic [NUM_STAGES-1:0] stage_ready;
    logic [NUM_STAGES-1:0] stage_reset_n;
    logic [IW-1:0]         stage_idx;
    logic                  busy;
    logic                  sys_running;
    logic                  fault;
    logic [IW-1:0]         fault_stage;
    modport master (
        output soft_req, stage_ready,
        input  stage_reset_n, stage_idx, busy, sys_running, fault, fault_stage
    );
    modport slave (
        input  soft_req, stage_ready,
        output stage_reset_n, stage_idx, busy, sys_running, fault, fault_stage
    );
endinterface

// File: rtl/reset_delay_counter.sv
// reset_delay_counter: clearable up-counter flagging done when it equals the terminal count.
module reset_delay_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] tc,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        cnt <= (reset || clr) ? '0 : cnt + W'(1);
    assign done = (cnt == tc);
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases core subsystems from reset one stage at a time after hold and gap delays.
// Optional macro RESET_TIMEOUT_EN: a stage whose ready never arrives is forced through after a timeout and flagged.
module reset_sequencer
    import gm64_reset_pkg::*;
#(
    parameter int NUM_STAGES     = RST_NUM_STAGES,
    parameter int HOLD_CYCLES    = RST_HOLD_CYCLES,
    parameter int STAGE_GAP      = RST_STAGE_GAP,
    parameter int TIMEOUT_CYCLES = RST_TIMEOUT_CYCLES
) (
    input logic               clk,
    input logic               reset,
    reset_sequencer_if.slave  ifc
);
    localparam int IW = $clog2(NUM_STAGES);
    localparam int CW = $clog2(max3(HOLD_CYCLES, STAGE_GAP, TIMEOUT_CYCLES)) + 1;

    rst_seq_state_t        state, state_nxt;
    logic [NUM_STAGES-1:0] rel, rel_nxt;
    logic [IW-1:0]         idx, idx_nxt, fst, fst_nxt;
    logic                  run, run_nxt, flt, flt_nxt;
    logic                  clr, done, last, timeout;
    logic [CW-1:0]         tc;

    assign tc   = (state == ASSERT) ? CW'(HOLD_CYCLES - 1) :
                  (state == GAP)    ? CW'(STAGE_GAP - 1)   : CW'(TIMEOUT_CYCLES - 1);
    assign last = (idx == IW'(NUM_STAGES - 1));

    reset_delay_counter #(.W(CW)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tc    (tc),
        .done  (done)
    );

    always_comb begin
        state_nxt = state;
        rel_nxt   = rel;
        idx_nxt   = idx;
        run_nxt   = run;
        flt_nxt   = flt;
        fst_nxt   = fst;
        clr       = 1'b0;
        timeout   = 1'b0;
        unique case (state)
            ASSERT: if (done) begin
                state_nxt = GAP;
                clr       = 1'b1;
            end
            GAP: if (done) begin
                rel_nxt[idx] = 1'b1;
                state_nxt    = WAIT_READY;
                clr          = 1'b1;
            end
            WAIT_READY: begin
`ifdef RESET_TIMEOUT_EN
                timeout = done && !ifc.stage_ready[idx];
`else
                clr = 1'b1;
`endif
                if (ifc.stage_ready[idx] || timeout) begin
                    clr = 1'b1;
                    if (timeout) begin
                        flt_nxt = 1'b1;
                        fst_nxt = flt ? fst : idx;
                    end
                    if (last) begin
                        state_nxt = RUN;
                        run_nxt   = 1'b1;
                    end else begin
                        idx_nxt   = idx + IW'(1);
                        state_nxt = GAP;
                    end
                end
            end
            default: ;
        endcase
        // soft_req beats every other transition and keeps the hold counter at zero
        if (ifc.soft_req) begin
            state_nxt = ASSERT;
            rel_nxt   = '0;
            run_nxt   = 1'b0;
            idx_nxt   = '0;
            clr       = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ASSERT;
            rel   <= '0;
            idx   <= '0;
            run   <= 1'b0;
            flt   <= 1'b0;
            fst   <= '0;
        end else begin
            state <= state_nxt;
            rel   <= rel_nxt;
            idx   <= idx_nxt;
            run   <= run_nxt;
            flt   <= flt_nxt;
            fst   <= fst_nxt;
        end
    end

    assign ifc.stage_reset_n = rel;
    assign ifc.stage_idx     = idx;
    assign ifc.busy          = (state != RUN);
    assign ifc.sys_running   = run;
    assign ifc.fault         = flt;
    assign ifc.fault_stage   = fst;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and random stimulus checked every cycle against an event-time reference model.
module tb_reset_sequencer;
    import gm64_reset_pkg::*;
    localparam int N  = RST_NUM_STAGES;
    localparam int IW = $clog2(N);
    localparam int OW = N + 2 * IW + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(N)) ifc ();
    reset_sequencer dut (.clk(clk), .reset(reset), .ifc(ifc));

    int total = 0;
    int bad   = 0;
    int e     = 0;

    logic [N-1:0] m_rel;
    int m_idx, m_fst, rel_edge, wait_start;
    bit m_run, m_wait, m_fault;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] outs();
        return {ifc.stage_reset_n, ifc.stage_idx, ifc.busy, ifc.sys_running, ifc.fault, ifc.fault_stage};
    endfunction

    // Stage i is released GAP edges after stage i-1 reported ready (HOLD+GAP after the last reset/soft_req edge for stage 0)
    task automatic model_edge();
        bit rdy, to;
        e++;
        if (reset) begin
            m_rel = '0; m_idx = 0; m_run = 0; m_wait = 0; m_fault = 0; m_fst = 0;
            rel_edge = e + RST_HOLD_CYCLES + RST_STAGE_GAP;
        end else if (ifc.soft_req) begin
            m_rel = '0; m_idx = 0; m_run = 0; m_wait = 0;
            rel_edge = e + RST_HOLD_CYCLES + RST_STAGE_GAP;
        end else if (m_wait) begin
            rdy = ifc.stage_ready[m_idx];
            to  = 0;
`ifdef RESET_TIMEOUT_EN
            to = (e - wait_start == RST_TIMEOUT_CYCLES);
`endif
            if (rdy || to) begin
                if (!rdy) begin
                    if (!m_fault) m_fst = m_idx;
                    m_fault = 1;
                end
                m_wait = 0;
                if (m_idx == N - 1) m_run = 1;
                else begin
                    m_idx++;
                    rel_edge = e + RST_STAGE_GAP;
                end
            end
        end else if (!m_run && e == rel_edge) begin
            m_rel[m_idx] = 1'b1;
            m_wait = 1;
            wait_start = e;
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk("outs", 32'(outs()),
                32'({m_rel, IW'(m_idx), !m_run, m_run, m_fault, IW'(m_fst)}));
        end
    endtask

    initial begin
        ifc.soft_req    = 1'b0;
        ifc.stage_ready = '1;
        step(3);
        chk("reset_state", 32'(outs()), 32'({N'(0), IW'(0), 1'b1, 1'b0, 1'b0, IW'(0)}));
        reset = 1'b0;
        e = 0;
        rel_edge = RST_HOLD_CYCLES + RST_STAGE_GAP;
        step(23);
        chk("pre_rel0", 32'(ifc.stage_reset_n), 32'(0));
        step(1);
        chk("rel0_e24", 32'(ifc.stage_reset_n), 32'(4'b0001));
        step(9);
        chk("rel1_e33", 32'(ifc.stage_reset_n), 32'(4'b0011));
        step(18);
        chk("rel3_e51", 32'({ifc.stage_reset_n, ifc.sys_running}), 32'({4'b1111, 1'b0}));
        step(1);
        chk("run_e52", 32'({ifc.sys_running, ifc.busy}), 32'(2'b10));

        ifc.soft_req = 1'b1;
        step(1);
        chk("soft_in_run", 32'({ifc.stage_reset_n, ifc.sys_running}), 32'(0));
        step(2);
        ifc.soft_req    = 1'b0;
        ifc.stage_ready = 4'b1101;
        step(80);
        chk("stall_stage1", 32'(ifc.stage_reset_n), 32'(4'b0011));
        ifc.stage_ready = '1;
        step(40);
        chk("run_after_stall", 32'({ifc.sys_running, ifc.fault}), 32'(2'b10));

        ifc.soft_req = 1'b1;
        step(1);
        ifc.soft_req = 1'b0;
        step(37);
        chk("in_gap2", 32'({ifc.stage_reset_n, ifc.stage_idx}), 32'({4'b0011, IW'(2)}));
        ifc.soft_req = 1'b1;
        step(1);
        chk("soft_in_gap", 32'({ifc.stage_reset_n, ifc.stage_idx, ifc.fault}), 32'(0));
        ifc.soft_req    = 1'b0;
        ifc.stage_ready = 4'b1011;
        step(1100);
`ifdef RESET_TIMEOUT_EN
        chk("timeout", 32'({ifc.fault, ifc.fault_stage, ifc.sys_running}), 32'({1'b1, IW'(2), 1'b1}));
`else
        chk("stall_no_to", 32'({ifc.stage_reset_n, ifc.fault, ifc.sys_running}), 32'({4'b0111, 2'b00}));
`endif
        ifc.soft_req = 1'b1;
        step(1);
        ifc.soft_req = 1'b0;
        step(50);
        reset = 1'b1;
        step(1);
        chk("reset_mid", 32'(outs()), 32'({N'(0), IW'(0), 1'b1, 1'b0, 1'b0, IW'(0)}));
        reset = 1'b0;

        repeat (2500) begin
            ifc.stage_ready = N'($urandom & $urandom);
            ifc.soft_req    = ($urandom_range(0, 79) == 0);
            reset           = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset        = 1'b0;
        ifc.soft_req = 1'b0;
        ifc.stage_ready = '1;
        step(60);
        chk("final_run", 32'(ifc.sys_running), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
